// File: rtl/dmawr2tlp_pkg.sv
// Shared types for the DMA write path: 64-bit AXIS beat with 2-bit sync
// sideband and the 32->64 pack state.
package dmawr2tlp_pkg;

  localparam logic [1:0] SYNC_NONE = 2'b00;
  localparam logic [1:0] SYNC_SOL  = 2'b01;
  localparam logic [1:0] SYNC_EOL  = 2'b10;

  typedef enum logic {
    PK_EMPTY,
    PK_HALF
  } pack_state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  user;
  } axis64_beat_t;

  // Build a beat from two 32-bit halves (first word in the low half).
  function automatic axis64_beat_t mk_beat(input logic [31:0] hi,
                                           input logic [31:0] lo,
                                           input logic        eol,
                                           input logic        sol);
    axis64_beat_t b;
    b.data = {hi, lo};
    b.user = (eol ? SYNC_EOL : SYNC_NONE) | (sol ? SYNC_SOL : SYNC_NONE);
    return b;
  endfunction

endpackage

// File: rtl/axis_pixel_packer64_skid.sv
// Generic 2-entry AXIS register slice: main register drives the output,
// skid register catches one beat while the output is stalled.
// o_ready depends only on flops (skid empty).
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 66
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic             r_main_valid, r_skid_valid;
  logic [WIDTH-1:0] r_main, r_skid;
  logic             w_main_valid_nxt, w_skid_valid_nxt;
  logic [WIDTH-1:0] w_main_nxt, w_skid_nxt;
  logic             w_drain;

  assign w_drain = r_main_valid & i_ready;

  // Next-state: refill main from skid first, otherwise take the new beat.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    if (r_skid_valid) begin
      if (w_drain) begin
        w_main_nxt       = r_skid;
        w_skid_valid_nxt = 1'b0;
      end
    end else if (i_valid) begin
      if (!r_main_valid || w_drain) begin
        w_main_nxt       = i_data;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_skid_nxt       = i_data;
        w_skid_valid_nxt = 1'b1;
      end
    end else if (w_drain) begin
      w_main_valid_nxt = 1'b0;
    end
  end

  // Slice registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
    end
  end

  assign o_ready = ~r_skid_valid;
  assign o_valid = r_main_valid;
  assign o_data  = r_main;

endmodule

// File: rtl/axis_pixel_packer64.sv
// Packs a 32-bit video AXIS stream into 64-bit beats with the 2-bit
// SOL/EOL sideband for the DMA write engine; pads odd lines, flags SOL
// inside an open line and counts completed output lines.
module axis_pixel_packer64
  import dmawr2tlp_pkg::*;
#(
  parameter logic [31:0] PAD_DATA       = 32'h0000_0000,
  parameter int unsigned LINE_CNT_WIDTH = 16
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [31:0]               s_axis_tdata,
  input  logic                      s_axis_tuser,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [63:0]               m_axis_tdata,
  output logic [1:0]                m_axis_tuser,
  output logic                      m_axis_tlast,
  input  logic                      clr_status,
  output logic [LINE_CNT_WIDTH-1:0] line_count,
  output logic                      err_sol_midline
);

  pack_state_t               r_state, w_state_nxt;
  logic [31:0]               r_low, w_low_nxt;
  logic                      r_low_sol, w_low_sol_nxt;
  logic                      r_line_open, w_line_open_nxt;
  logic                      r_pend_valid, w_pend_valid_nxt;
  axis64_beat_t              r_pend, w_pend_nxt;
  logic                      r_err;
  logic [LINE_CNT_WIDTH-1:0] r_line_count;
  logic                      r_started;

  logic                      w_accept, w_midline_sol;
  logic                      w_push;
  axis64_beat_t              w_push_beat, w_out_beat;
  logic                      w_skid_ready, w_out_valid;

  // Input stalls while the skid is occupied or a second beat is parked.
  assign s_axis_tready = r_started & w_skid_ready & ~r_pend_valid;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_midline_sol = w_accept & s_axis_tuser & r_line_open;

  // Pack FSM next-state and beat generation.
  // A SOL+EOL word arriving in HALF of an open line needs two beats in one
  // cycle (pad-close plus the single-beat line); the second is parked in
  // r_pend and pushed once the slice has room, holding off input meanwhile.
  always_comb begin
    w_state_nxt      = r_state;
    w_low_nxt        = r_low;
    w_low_sol_nxt    = r_low_sol;
    w_line_open_nxt  = r_line_open;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_nxt       = r_pend;
    w_push           = 1'b0;
    w_push_beat      = '0;
    if (r_pend_valid) begin
      if (w_skid_ready) begin
        w_push           = 1'b1;
        w_push_beat      = r_pend;
        w_pend_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_line_open_nxt = ~s_axis_tlast;
      case (r_state)
        PK_EMPTY: begin
          if (s_axis_tlast) begin
            w_push      = 1'b1;
            w_push_beat = mk_beat(PAD_DATA, s_axis_tdata, 1'b1, s_axis_tuser);
          end else begin
            w_low_nxt     = s_axis_tdata;
            w_low_sol_nxt = s_axis_tuser;
            w_state_nxt   = PK_HALF;
          end
        end
        PK_HALF: begin
          if (w_midline_sol) begin
            w_push      = 1'b1;
            w_push_beat = mk_beat(PAD_DATA, r_low, 1'b1, r_low_sol);
            if (s_axis_tlast) begin
              w_pend_valid_nxt = 1'b1;
              w_pend_nxt       = mk_beat(PAD_DATA, s_axis_tdata, 1'b1, 1'b1);
              w_state_nxt      = PK_EMPTY;
            end else begin
              w_low_nxt     = s_axis_tdata;
              w_low_sol_nxt = 1'b1;
            end
          end else begin
            w_push      = 1'b1;
            w_push_beat = mk_beat(s_axis_tdata, r_low, s_axis_tlast, r_low_sol);
            w_state_nxt = PK_EMPTY;
          end
        end
        default: w_state_nxt = PK_EMPTY;
      endcase
    end
  end

  // Pack state registers.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state      <= PK_EMPTY;
      r_low        <= '0;
      r_low_sol    <= 1'b0;
      r_line_open  <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
      r_started    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_low        <= w_low_nxt;
      r_low_sol    <= w_low_sol_nxt;
      r_line_open  <= w_line_open_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend       <= w_pend_nxt;
      r_started    <= 1'b1;
    end
  end

  axis_skid_buffer #(
    .WIDTH($bits(axis64_beat_t))
  ) u_skid (
    .i_clk   (axi_clk),
    .i_rst   (axi_reset),
    .i_valid (w_push),
    .i_data  (w_push_beat),
    .o_ready (w_skid_ready),
    .o_valid (w_out_valid),
    .o_data  (w_out_beat),
    .i_ready (m_axis_tready)
  );

  assign m_axis_tvalid = w_out_valid;
  assign m_axis_tdata  = w_out_beat.data;
  assign m_axis_tuser  = w_out_beat.user;
  assign m_axis_tlast  = w_out_beat.user[1];

  // Status: line counter (clear beats increment) and sticky SOL error
  // (a new error in the clear cycle is kept so it is not lost).
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_line_count <= '0;
      r_err        <= 1'b0;
    end else begin
      if (clr_status)
        r_line_count <= '0;
      else if (w_out_valid && m_axis_tready && w_out_beat.user[1])
        r_line_count <= r_line_count + 1'b1;
      if (w_midline_sol)
        r_err <= 1'b1;
      else if (clr_status)
        r_err <= 1'b0;
    end
  end

  assign line_count      = r_line_count;
  assign err_sol_midline = r_err;

endmodule

// File: tb/tb_axis_pixel_packer64.sv
// Directed + randomized bench for axis_pixel_packer64 with a line-level
// reference model (beats computed from whole lines).
module tb_axis_pixel_packer64;

  localparam logic [31:0] PAD = 32'h0000_0000;
  localparam int unsigned LCW = 16;

  logic            axi_clk = 1'b0;
  logic            axi_reset = 1'b1;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [31:0]     s_axis_tdata = '0;
  logic            s_axis_tuser = 1'b0;
  logic            s_axis_tlast = 1'b0;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic [63:0]     m_axis_tdata;
  logic [1:0]      m_axis_tuser;
  logic            m_axis_tlast;
  logic            clr_status = 1'b0;
  logic [LCW-1:0]  line_count;
  logic            err_sol_midline;

  always #5 axi_clk = ~axi_clk;

  axis_pixel_packer64 #(
    .PAD_DATA       (PAD),
    .LINE_CNT_WIDTH (LCW)
  ) u_dut (
    .axi_clk         (axi_clk),
    .axi_reset       (axi_reset),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tlast    (m_axis_tlast),
    .clr_status      (clr_status),
    .line_count      (line_count),
    .err_sol_midline (err_sol_midline)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned viol = 0;
  bit          rand_ready = 1'b0;
  logic [66:0] exp_q[$];
  logic [66:0] obs_q[$];
  logic [31:0] line_q[$];

  function automatic logic [66:0] pk(input logic [63:0] d, input logic [1:0] u);
    return {d, u, u[1]};
  endfunction

  // Record every output handshake; watch ready against a full skid slot.
  always @(negedge axi_clk) begin
    if (!axi_reset) begin
      if (m_axis_tvalid && m_axis_tready)
        obs_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
      if (s_axis_tready && u_dut.u_skid.r_skid_valid)
        viol++;
    end
  end

  task automatic chk(input string tag, input logic [66:0] o, input logic [66:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [31:0] d, input logic sol, input logic eol);
    int unsigned n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = sol;
    s_axis_tlast  = eol;
    @(negedge axi_clk);
    while (!s_axis_tready && n < 2000) begin
      step();
      @(negedge axi_clk);
      n++;
    end
    if (!s_axis_tready) chk("accept_timeout", 67'(s_axis_tready), 67'(1));
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Reference: beat k of a line is {word[2k+1] or PAD, word[2k]},
  // SOL on beat 0 (if the line started with SOL), EOL on the final beat.
  task automatic model_line(input logic sol);
    int n;
    logic [31:0] lo, hi;
    logic [1:0]  u;
    n = int'(line_q.size());
    for (int i = 0; i < n; i += 2) begin
      lo = line_q[i];
      hi = (i + 1 < n) ? line_q[i+1] : PAD;
      u  = {(i + 2 >= n), (sol && i == 0)};
      exp_q.push_back(pk({hi, lo}, u));
    end
  endtask

  task automatic send_line(input logic sol, input bit gaps);
    int n;
    n = int'(line_q.size());
    for (int i = 0; i < n; i++) begin
      send_word(line_q[i], sol && (i == 0), i == n - 1);
      if (gaps && $urandom_range(0, 3) == 0) step();
    end
    model_line(sol);
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    int m;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 20000) begin
      step();
      n++;
    end
    step();
    step();
    chk({tag, "_beats"}, 67'(obs_q.size()), 67'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? int'(obs_q.size()) : int'(exp_q.size());
    for (int i = 0; i < m; i++) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_tvalid", 67'(m_axis_tvalid), 67'(0));
    chk("rst_tdata",  67'(m_axis_tdata),  67'(0));
    chk("rst_tuser",  67'(m_axis_tuser),  67'(0));
    chk("rst_tlast",  67'(m_axis_tlast),  67'(0));
    chk("rst_sready", 67'(s_axis_tready), 67'(0));
    chk("rst_count",  67'(line_count),    67'(0));
    chk("rst_err",    67'(err_sol_midline), 67'(0));
    axi_reset = 1'b0;
    @(negedge axi_clk);
    chk("sready_first_cycle", 67'(s_axis_tready), 67'(0));
    step();
    chk("sready_after", 67'(s_axis_tready), 67'(1));

    // Single-word line: SOL+EOL, padded, visible the cycle after accept
    send_word(32'hCAFE_FADE, 1'b1, 1'b1);
    chk("single_valid", 67'(m_axis_tvalid), 67'(1));
    chk("single_beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast},
        pk({PAD, 32'hCAFE_FADE}, 2'b11));
    exp_q.push_back(pk({PAD, 32'hCAFE_FADE}, 2'b11));
    step();
    chk("single_count", 67'(line_count), 67'(1));
    drain("single");

    // Three-word line
    line_q.delete();
    line_q.push_back(32'hAAAA_0001);
    line_q.push_back(32'hBBBB_0002);
    line_q.push_back(32'hCCCC_0003);
    send_line(1'b1, 1'b0);
    drain("three");
    chk("three_count", 67'(line_count), 67'(2));

    // 0x400-word counter line
    pulse_clr();
    chk("clr_count", 67'(line_count), 67'(0));
    line_q.delete();
    for (int i = 0; i < 32'h400; i++) line_q.push_back(32'(i));
    send_line(1'b1, 1'b0);
    drain("counter");
    chk("counter_count", 67'(line_count), 67'(1));

    // Random data, random backpressure, input gaps
    pulse_clr();
    viol = 0;
    rand_ready = 1'b1;
    repeat (8) begin
      line_q.delete();
      repeat (512) line_q.push_back($urandom);
      send_line(1'b1, 1'b1);
    end
    drain("random");
    rand_ready = 1'b0;
    m_axis_tready = 1'b1;
    step();
    chk("random_count", 67'(line_count), 67'(8));
    chk("skid_full_ready", 67'(viol), 67'(0));

    // SOL after 5 words of an open line
    pulse_clr();
    line_q.delete();
    for (int i = 0; i < 5; i++) line_q.push_back(32'h5000_0000 + 32'(i));
    for (int i = 0; i < 5; i++) send_word(line_q[i], i == 0, 1'b0);
    model_line(1'b1);
    line_q.delete();
    line_q.push_back(32'h7777_0000);
    line_q.push_back(32'h7777_0001);
    send_line(1'b1, 1'b0);
    step();
    chk("midsol_err", 67'(err_sol_midline), 67'(1));
    drain("midsol");
    chk("midsol_count", 67'(line_count), 67'(2));
    pulse_clr();
    chk("midsol_clr_count", 67'(line_count), 67'(0));
    chk("midsol_clr_err", 67'(err_sol_midline), 67'(0));

    // SOL+EOL arriving in HALF with stalled output: two beats needed
    m_axis_tready = 1'b0;
    line_q.delete();
    for (int i = 0; i < 3; i++) line_q.push_back(32'h9000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) send_word(line_q[i], i == 0, 1'b0);
    send_word(32'hD00D_F00D, 1'b1, 1'b1);
    chk("dbl_sready_low", 67'(s_axis_tready), 67'(0));
    chk("dbl_err", 67'(err_sol_midline), 67'(1));
    model_line(1'b1);
    exp_q.push_back(pk({PAD, 32'hD00D_F00D}, 2'b11));
    m_axis_tready = 1'b1;
    drain("dbl");
    chk("dbl_count", 67'(line_count), 67'(2));
    chk("dbl_viol", 67'(viol), 67'(0));
    pulse_clr();

    // Reset while HALF with a stalled output beat
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_word(32'hBAD0_0000 + 32'(i), i == 0, 1'b0);
    chk("pre_rst_valid", 67'(m_axis_tvalid), 67'(1));
    axi_reset = 1'b1;
    #1;
    chk("rst_mid_valid", 67'(m_axis_tvalid), 67'(0));
    chk("rst_mid_data", 67'(m_axis_tdata), 67'(0));
    repeat (2) @(posedge axi_clk);
    #1;
    axi_reset = 1'b0;
    step();
    step();
    obs_q.delete();
    exp_q.delete();
    m_axis_tready = 1'b1;
    line_q.delete();
    line_q.push_back(32'h1111_1111);
    line_q.push_back(32'h2222_2222);
    line_q.push_back(32'h3333_3333);
    send_line(1'b1, 1'b0);
    drain("post_rst");
    chk("post_rst_count", 67'(line_count), 67'(1));
    chk("post_rst_err", 67'(err_sol_midline), 67'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
